// File: rtl/wavetable_scheduler.sv
// wavetable_scheduler: shares one wavetable ROM among NUM_VOICES oscillators,
// servicing each active voice once per sample tick in ascending order.
module wavetable_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int A_WIDTH    = 12,
    parameter int ROM_LAT    = 2
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          sampleTick,
    input  logic [NUM_VOICES-1:0]         voiceActive,
    input  logic [NUM_VOICES*A_WIDTH-1:0] addrIn,
    output logic [NUM_VOICES-1:0]         voiceEn,
    output logic [NUM_VOICES-1:0]         voiceLoad,
    output logic [A_WIDTH-1:0]            romAddr,
    output logic                          romRd,
    output logic [3:0]                    voiceSel,
    output logic                          busy,
    output logic                          frameDone,
    output logic                          overrun
);
    localparam int CW = ROM_LAT > 2 ? $clog2(ROM_LAT - 1) : 1;

    typedef enum logic [2:0] {IDLE, ENABLE, READ, WAIT, LOAD, DONE} state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [3:0]             sel, sel_n, first, next;
    logic                   first_ok, next_ok, start;
    logic [NUM_VOICES-1:0]  mask_r;
    logic [A_WIDTH-1:0]     addr_r;

    assign start = sampleTick && (state == IDLE || state == DONE);

    // Lowest active voice for a new frame, and next set mask bit above the current voice.
    always_comb begin
        first    = '0;
        first_ok = 1'b0;
        next     = '0;
        next_ok  = 1'b0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voiceActive[i]) begin
                first    = 4'(i);
                first_ok = 1'b1;
            end
            if (mask_r[i] && i > int'(sel)) begin
                next    = 4'(i);
                next_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sel     <= '0;
            mask_r  <= '0;
            addr_r  <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sel     <= sel_n;
            mask_r  <= start ? voiceActive : mask_r;
            addr_r  <= state == READ ? romAddr : addr_r;
            overrun <= overrun | (sampleTick & busy);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        case (state)
            IDLE, DONE: begin
                state_n = !start ? IDLE : first_ok ? ENABLE : DONE;
                sel_n   = (start && first_ok) ? first : sel;
            end
            ENABLE: state_n = READ;
            READ: begin
                state_n = ROM_LAT == 1 ? LOAD : WAIT;
                cnt_n   = CW'(ROM_LAT - 2);
            end
            WAIT: begin
                state_n = cnt == '0 ? LOAD : WAIT;
                cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
            end
            LOAD: begin
                state_n = next_ok ? ENABLE : DONE;
                sel_n   = next_ok ? next : sel;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        voiceEn   = state == ENABLE ? NUM_VOICES'(1) << sel : '0;
        voiceLoad = state == LOAD ? NUM_VOICES'(1) << sel : '0;
        romRd     = state == READ;
        romAddr   = state == READ ? addrIn[int'(sel)*A_WIDTH +: A_WIDTH] : addr_r;
        voiceSel  = sel;
        busy      = state == ENABLE || state == READ || state == WAIT || state == LOAD;
        frameDone = state == DONE;
    end
endmodule
